// File: rtl/vectorsum_arbiter_pkg.sv
// Shared types and helpers for the two-client vectorsum arbiter.
package vectorsum_pkg;

    typedef enum logic {S_IDLE, S_BURST} arb_state_t;

    localparam int NUM_CLIENTS = 2;

    // Round-robin winner: the client other than the last owner wins a tie,
    // otherwise the single candidate wins.
    function automatic logic rr_pick(input logic [NUM_CLIENTS-1:0] cand, input logic last);
        if (cand[0] && cand[1]) begin
            return ~last;
        end
        return cand[1];
    endfunction

endpackage

// File: rtl/vectorsum_arbiter_if.sv
// Client-facing and vectorsum_top-facing signals of the arbiter, bundled.
interface vectorsum_arbiter_if
    import vectorsum_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    // client side
    logic [NUM_CLIENTS-1:0]                 req;
    logic [NUM_CLIENTS-1:0][LEN_WIDTH-1:0]  len;
    logic [NUM_CLIENTS-1:0]                 gnt;
    logic [NUM_CLIENTS-1:0]                 valid;
    logic [NUM_CLIENTS-1:0]                 ready;
    logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] xin;
    logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] yin;
    logic [NUM_CLIENTS-1:0]                 zvalid;
    logic [NUM_CLIENTS-1:0]                 zready;
    logic [DATA_WIDTH-1:0]                  zout;
    // vectorsum_top side
    logic                                   x_wr_en;
    logic                                   y_wr_en;
    logic [DATA_WIDTH-1:0]                  x_din;
    logic [DATA_WIDTH-1:0]                  y_din;
    logic                                   x_full;
    logic                                   y_full;
    logic                                   z_rd_en;
    logic [DATA_WIDTH-1:0]                  z_dout;
    logic                                   z_empty;

    // The arbiter itself.
    modport slave (
        input  req, len, valid, xin, yin, zready, x_full, y_full, z_dout, z_empty,
        output gnt, ready, zvalid, zout, x_wr_en, y_wr_en, x_din, y_din, z_rd_en
    );

    // Clients plus the shared vectorsum_top.
    modport master (
        output req, len, valid, xin, yin, zready, x_full, y_full, z_dout, z_empty,
        input  gnt, ready, zvalid, zout, x_wr_en, y_wr_en, x_din, y_din, z_rd_en
    );
endinterface

// File: rtl/vectorsum_arbiter_fifo.sv
// Show-ahead FIFO; used here as the 1-bit owner-tag queue. The head is read
// combinationally so the tag is known in the same cycle z data appears.
module fifo #(
    parameter int FIFO_DATA_WIDTH  = 32,
    parameter int FIFO_BUFFER_SIZE = 16
) (
    input  logic                       wr_clk,
    input  logic                       rd_clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0] din,
    output logic                       full,
    input  logic                       rd_en,
    output logic [FIFO_DATA_WIDTH-1:0] dout,
    output logic                       empty
);
    localparam int AW = (FIFO_BUFFER_SIZE > 1) ? $clog2(FIFO_BUFFER_SIZE) : 1;
    localparam logic [AW-1:0] LAST = AW'(FIFO_BUFFER_SIZE - 1);

    logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic          wr_wrap_reg, rd_wrap_reg;
    logic          do_wr, do_rd;

    // Wrap bits distinguish full from empty when the pointers coincide.
    assign empty = (wr_ptr_reg == rd_ptr_reg) && (wr_wrap_reg == rd_wrap_reg);
    assign full  = (wr_ptr_reg == rd_ptr_reg) && (wr_wrap_reg != rd_wrap_reg);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rd_ptr_reg];

    // Write pointer advance, wrapping at the buffer size.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            wr_wrap_reg <= 1'b0;
        end else if (do_wr) begin
            wr_ptr_reg  <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
            wr_wrap_reg <= (wr_ptr_reg == LAST) ? ~wr_wrap_reg : wr_wrap_reg;
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge wr_clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Read pointer advance, wrapping at the buffer size.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            rd_ptr_reg  <= '0;
            rd_wrap_reg <= 1'b0;
        end else if (do_rd) begin
            rd_ptr_reg  <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
            rd_wrap_reg <= (rd_ptr_reg == LAST) ? ~rd_wrap_reg : rd_wrap_reg;
        end
    end
endmodule

// File: rtl/vectorsum_arbiter.sv
// Two-client round-robin burst arbiter in front of vectorsum_top. Each
// forwarded element records its owner in a tag queue so z results are
// steered back to the issuing client in order.
module vectorsum_arbiter
    import vectorsum_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int TAG_DEPTH  = 128
) (
    input  logic               clock,
    input  logic               reset,
    vectorsum_arbiter_if.slave bus
);
    arb_state_t             state_reg, state_next;
    logic [LEN_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                   gid_reg, gid_next;
    logic                   last_reg, last_next;

    logic [NUM_CLIENTS-1:0] cand;
    logic                   win;
    logic                   in_burst;
    logic                   accept_ok;
    logic                   xfer;
    logic                   z_avail;
    logic                   tag_full, tag_empty, tag_head, tag_pop;
    logic [DATA_WIDTH-1:0]  x_sel, y_sel;

    // Outputs are forced low while reset is high so nothing leaks mid-reset.
    assign in_burst  = !reset && (state_reg == S_BURST);
    assign accept_ok = in_burst && !bus.x_full && !bus.y_full && !tag_full;
    assign xfer      = accept_ok && bus.valid[gid_reg];
    assign win       = rr_pick(cand, last_reg);
    assign x_sel     = bus.xin[gid_reg];
    assign y_sel     = bus.yin[gid_reg];

    assign bus.x_wr_en = xfer;
    assign bus.y_wr_en = xfer;
    assign bus.x_din   = xfer ? x_sel : '0;
    assign bus.y_din   = xfer ? y_sel : '0;

    // Return path: head tag owns whatever sits at the z FIFO head.
    assign z_avail     = !reset && !bus.z_empty && !tag_empty;
    assign tag_pop     = z_avail && bus.zready[tag_head];
    assign bus.z_rd_en = tag_pop;
    assign bus.zout    = reset ? '0 : bus.z_dout;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
            assign cand[gi]       = bus.req[gi] && (bus.len[gi] != '0);
            assign bus.gnt[gi]    = in_burst && (gid_reg == 1'(gi));
            assign bus.ready[gi]  = accept_ok && (gid_reg == 1'(gi));
            assign bus.zvalid[gi] = z_avail && (tag_head == 1'(gi));
        end
    endgenerate

    // State, burst counter, owner and round-robin history registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            gid_reg   <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            gid_reg   <= gid_next;
            last_reg  <= last_next;
        end
    end

    // Grant selection in idle; count down accepted elements in a burst.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gid_next   = gid_reg;
        last_next  = last_reg;
        case (state_reg)
            S_IDLE: begin
                if (|cand) begin
                    gid_next   = win;
                    cnt_next   = bus.len[win];
                    state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (xfer) begin
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == LEN_WIDTH'(1)) begin
                        state_next = S_IDLE;
                        last_next  = gid_reg;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    fifo #(
        .FIFO_DATA_WIDTH (1),
        .FIFO_BUFFER_SIZE(TAG_DEPTH)
    ) u_tag_q (
        .wr_clk(clock),
        .rd_clk(clock),
        .reset (reset),
        .wr_en (xfer),
        .din   (gid_reg),
        .full  (tag_full),
        .rd_en (tag_pop),
        .dout  (tag_head),
        .empty (tag_empty)
    );
endmodule

// File: tb/tb_vectorsum_arbiter.sv
// Directed bench for vectorsum_arbiter with a small behavioural vectorsum_top
// (8-deep x/y FIFOs, adder, 8-deep z FIFO). Drive and sample on negedge.
module tb_vectorsum_arbiter;
    import vectorsum_pkg::*;

    localparam int DW = 32;
    localparam int LW = 8;
    localparam int TD = 128;
    localparam int FD = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vectorsum_arbiter_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    vectorsum_arbiter #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TAG_DEPTH(TD)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- vectorsum_top model ----------------
    logic [DW-1:0] xm [FD];
    logic [DW-1:0] ym [FD];
    logic [DW-1:0] zm [FD];
    int xc = 0, zc = 0, xw = 0, xr = 0, zw = 0, zr = 0;
    logic m_wr, m_mv, m_rd;

    assign bus.x_full  = (xc == FD);
    assign bus.y_full  = (xc == FD);
    assign bus.z_empty = (zc == 0);
    assign bus.z_dout  = zm[zr];
    assign m_wr = bus.x_wr_en && !bus.x_full;
    assign m_mv = (xc != 0) && (zc != FD);
    assign m_rd = bus.z_rd_en && !bus.z_empty;

    always @(posedge clock) begin
        if (reset) begin
            xc <= 0; zc <= 0; xw <= 0; xr <= 0; zw <= 0; zr <= 0;
        end else begin
            if (m_wr) begin
                xm[xw] <= bus.x_din;
                ym[xw] <= bus.y_din;
                xw <= (xw + 1) % FD;
            end
            if (m_mv) begin
                zm[zw] <= xm[xr] + ym[xr];
                xr <= (xr + 1) % FD;
                zw <= (zw + 1) % FD;
            end
            if (m_rd) zr <= (zr + 1) % FD;
            xc <= xc + int'(m_wr) - int'(m_mv);
            zc <= zc + int'(m_mv) - int'(m_rd);
        end
    end

    // ---------------- result collector ----------------
    typedef struct packed { logic c; logic [DW-1:0] d; } res_t;
    res_t got[$];
    res_t exp_q[$];
    int zrd_cnt = 0;
    int zv1_cnt = 0;

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++)
                if (bus.zvalid[i] && bus.zready[i]) got.push_back('{c: 1'(i), d: bus.zout});
            if (bus.z_rd_en) zrd_cnt++;
            if (bus.zvalid[1]) zv1_cnt++;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    task automatic send_burst(input int c, input int n, input int xb, input int xs,
                              input int yb, input int ys, output int lat);
        int g;
        int k;
        bus.req[c] = 1'b1;
        bus.len[c] = LW'(n);
        g = 0;
        @(negedge clock);
        while (!bus.gnt[c] && g < 300) begin @(negedge clock); g++; end
        lat = g + 1;
        bus.req[c] = 1'b0;
        if (!bus.gnt[c]) begin
            check("grant_timeout", 0, 1);
            return;
        end
        k = 0;
        g = 0;
        while (k < n && g < 3000) begin
            bus.valid[c] = 1'b1;
            bus.xin[c] = DW'(xb + k * xs);
            bus.yin[c] = DW'(yb + k * ys);
            if (bus.ready[c]) begin
                exp_q.push_back('{c: 1'(c), d: DW'(xb + k * xs + yb + k * ys)});
                k++;
            end
            @(negedge clock);
            g++;
        end
        bus.valid[c] = 1'b0;
        if (k < n) check("burst_timeout", 64'(k), 64'(n));
    endtask

    task automatic wait_results(input string tag, input int n);
        int g = 0;
        while (got.size() < n && g < 1000) begin @(negedge clock); g++; end
        repeat (4) @(negedge clock);
        check({tag, "_count"}, 64'(got.size()), 64'(n));
    endtask

    task automatic drain_compare(input string tag);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            $display("txn %s[%0d]: client %0d z=%0d", tag, i, got[i].c, got[i].d);
            check({tag, "_tag"}, 64'(got[i].c), 64'(exp_q[i].c));
            check({tag, "_data"}, 64'(got[i].d), 64'(exp_q[i].d));
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat0, lat1, base, k, g;

        bus.req = '0; bus.len = '0; bus.valid = '0;
        bus.xin = '0; bus.yin = '0; bus.zready = 2'b11;

        // ---- reset state ----
        repeat (3) @(negedge clock);
        check("rst_zout", 64'(bus.zout), 0);
        check("rst_gnt", 64'(bus.gnt), 0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", 64'(bus.ready), 0);
        check("rst_zvalid", 64'(bus.zvalid), 0);
        check("rst_wr_en", 64'(bus.x_wr_en), 0);
        check("rst_z_rd_en", 64'(bus.z_rd_en), 0);

        // ---- zero length request is ignored ----
        bus.req[1] = 1'b1; bus.len[1] = '0;
        repeat (3) begin
            @(negedge clock);
            check("zero_len_gnt", 64'(bus.gnt), 0);
            check("zero_len_state", 64'(dut.state_reg), 64'(S_IDLE));
        end
        bus.req[1] = 1'b0;
        @(negedge clock);

        // ---- single client: z = 11,22,33,44 ----
        base = zv1_cnt;
        send_burst(0, 4, 1, 1, 10, 10, lat0);
        check("single_gnt_latency", 64'(lat0), 1);
        wait_results("single", 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            check("single_const_tag", 64'(got[i].c), 0);
            check("single_const_data", 64'(got[i].d), 64'(11 * (i + 1)));
        end
        check("single_zvalid1_quiet", 64'(zv1_cnt - base), 0);
        drain_compare("single");

        // ---- contention: both len=2 ----
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        fork
            send_burst(0, 2, 5, 1, 100, 100, lat0);
            send_burst(1, 2, 7, 1, 300, 100, lat1);
        join
        check("rr_lat_client0", 64'(lat0), 1);
        check("rr_lat_client1", 64'(lat1), 4);
        wait_results("rr", 4);
        if (got.size() >= 4) begin
            check("rr_tag0", 64'(got[0].c), 0);
            check("rr_tag1", 64'(got[1].c), 0);
            check("rr_tag2", 64'(got[2].c), 1);
            check("rr_tag3", 64'(got[3].c), 1);
            check("rr_data0", 64'(got[0].d), 105);
            check("rr_data3", 64'(got[3].d), 408);
        end
        drain_compare("rr");

        // ---- backpressure: len=40 with z consumer stalled ----
        bus.zready[0] = 1'b0;
        fork
            send_burst(0, 40, 0, 1, 1000, 1, lat0);
            begin
                g = 0;
                while (!bus.x_full && g < 300) begin @(negedge clock); g++; end
                check("bp_full_seen", 64'(bus.x_full), 1);
                repeat (4) begin
                    check("bp_ready_low", 64'(bus.ready[0]), 0);
                    check("bp_gnt_held", 64'(bus.gnt[0]), 1);
                    @(negedge clock);
                end
                bus.zready[0] = 1'b1;
            end
        join
        wait_results("bp", 40);
        drain_compare("bp");

        // ---- return stall: len=8, zready low until z FIFO full ----
        bus.zready[0] = 1'b0;
        base = zrd_cnt;
        send_burst(0, 8, 20, 1, 50, 2, lat0);
        repeat (6) @(negedge clock);
        check("stall_no_rd_en", 64'(zrd_cnt - base), 0);
        check("stall_zvalid0", 64'(bus.zvalid), 1);
        check("stall_z_full", 64'(zc), 64'(FD));
        bus.zready[0] = 1'b1;
        wait_results("stall", 8);
        check("stall_pops", 64'(zrd_cnt - base), 8);
        drain_compare("stall");

        // ---- reset mid-burst after 3 of 6 ----
        bus.req[0] = 1'b1; bus.len[0] = LW'(6);
        g = 0;
        @(negedge clock);
        while (!bus.gnt[0] && g < 50) begin @(negedge clock); g++; end
        bus.req[0] = 1'b0;
        k = 0;
        g = 0;
        while (k < 3 && g < 100) begin
            bus.valid[0] = 1'b1;
            bus.xin[0] = DW'(k + 1);
            bus.yin[0] = DW'(10);
            if (bus.ready[0]) k++;
            @(negedge clock);
            g++;
        end
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_gnt", 64'(bus.gnt), 0);
        check("mid_rst_ready", 64'(bus.ready), 0);
        check("mid_rst_zvalid", 64'(bus.zvalid), 0);
        check("mid_rst_wr", 64'({bus.x_wr_en, bus.y_wr_en, bus.z_rd_en}), 0);
        check("mid_rst_din", 64'(bus.x_din | bus.y_din), 0);
        check("mid_rst_zout", 64'(bus.zout), 0);
        check("mid_rst_tag_empty", 64'(dut.tag_empty), 1);
        reset = 1'b0;
        bus.valid[0] = 1'b0;
        got.delete();
        exp_q.delete();
        @(negedge clock);
        check("post_rst_gnt", 64'(bus.gnt), 0);
        send_burst(1, 2, 3, 1, 4, 1, lat1);
        check("post_rst_lat", 64'(lat1), 1);
        wait_results("post_rst", 2);
        if (got.size() >= 2) begin
            check("post_rst_data0", 64'(got[0].d), 7);
            check("post_rst_data1", 64'(got[1].d), 9);
            check("post_rst_tag", 64'(got[1].c), 1);
        end
        drain_compare("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vectorsum_arbiter.md
# vectorsum_arbiter

Two-client round-robin arbiter that shares one `vectorsum_top` instance (x/y input FIFOs, adder, z output FIFO) between two requesters. Each client wins a burst of N element pairs, which the arbiter forwards into the x/y FIFO write ports. A 1-bit tag queue records the owner of every forwarded element, so each z result is steered back to the client that issued it, in order. The block sits directly in front of `vectorsum_top`, and both share `clock` and `reset`.

## Interface
- `DATA_WIDTH`, 32: element width; must match `vectorsum_top`.
- `LEN_WIDTH`, 8: burst-length field width; maximum burst is 2^LEN_WIDTH-1.
- `TAG_DEPTH`, 128: tag-queue depth; must be ≥ 3×`FIFO_BUFFER_SIZE` of `vectorsum_top`.
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  [1:0]  per-client burst request; level, held until `gnt` is seen.
- `len`  in  [1:0][LEN_WIDTH-1:0]  burst length; sampled at grant.
- `gnt`  out  [1:0]  one-hot burst grant; high for the whole burst.
- `valid`  in  [1:0]  client element valid.
- `ready`  out  [1:0]  element accepted when `valid[i]&ready[i]`.
- `xin`, `yin`  in  [1:0][DATA_WIDTH-1:0]  client operands.
- `zvalid`  out  [1:0]  result available for client i.
- `zready`  in  [1:0]  client consumes result.
- `zout`  out  DATA_WIDTH  result data, shared by both clients; qualify with `zvalid`.
- `x_wr_en`, `y_wr_en`  out  1  write strobes to `vectorsum_top`.
- `x_din`, `y_din`  out  DATA_WIDTH  operands to `vectorsum_top`.
- `x_full`, `y_full`  in  1  from `vectorsum_top`.
- `z_rd_en`  out  1  pop of the z FIFO.
- `z_dout`  in  DATA_WIDTH  z FIFO head, show-ahead: valid whenever `!z_empty`.
- `z_empty`  in  1  from `vectorsum_top`.

## Operation
- **State machine**, two states:
  - `S_IDLE`: `gnt=0`, `ready=0`.
  - Candidates are clients with `req[i]=1` and `len[i]!=0`. Requests with `len=0` are ignored and never granted.
  - Round-robin choice: the client other than `last` wins when both are candidates; otherwise the single candidate wins.
  - On a win: latch `cnt<=len[g]`, `gid<=g`, go to `S_BURST`.
  - `S_BURST`: `gnt[gid]=1`; `ready[gid] = !x_full & !y_full & !tag_full`; `ready[~gid]=0`.
  - Transfer when `valid[gid]&ready[gid]`: `x_wr_en=y_wr_en=1`, `x_din=xin[gid]`, `y_din=yin[gid]`, push `gid` into the tag queue, `cnt<=cnt-1`.
  - A transfer with `cnt==1` returns to `S_IDLE` and sets `last<=gid`.
- **Return path**, combinational and independent of the state machine:
  - `head` = tag-queue head.
  - `zvalid[head] = !z_empty & !tag_empty`; the other `zvalid` bit is 0.
  - `z_rd_en = zvalid[head] & zready[head]`. The tag-queue pop occurs in the same cycle.
  - `zout = z_dout`.
- **Tag-queue boundary conditions**:
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Push is never attempted while the queue is full, because `ready` already includes `!tag_full`.
  - `z_empty=0` with the tag queue empty is impossible by construction; the block must not pop in that case.
- **Reset**, effective mid-burst or at any time:
  - State goes to `S_IDLE`, `cnt=0`, `gid=0`, `last=1` (client 0 wins first tie), tag queue emptied.
  - All outputs low: `gnt`, `ready`, `zvalid`, `x_wr_en`, `y_wr_en`, `z_rd_en`, `x_din`, `y_din`, `zout` (data driven 0).
  - Any partial burst is discarded. The owning `vectorsum_top` FIFOs are reset in the same cycle.

## Timing
- Request to grant: `req` high in `S_IDLE` at cycle t gives `gnt` at t+1. The first element can be accepted at t+1.
- Throughput: one element per cycle in `S_BURST` while the client is valid and there is no backpressure.
- Bursts are separated by exactly one `S_IDLE` cycle.
- `ready`, `x_wr_en`, `y_wr_en`, `zvalid` and `z_rd_en` are combinational from current state and inputs; no registered output stage.
- `x_full` or `y_full` rising mid-burst drops `ready` in the same cycle. The burst stalls but stays granted, and `cnt` holds.
- A stalled client (`valid=0`) holds the grant indefinitely. No timeout.

## Structure
- Package `vectorsum_pkg`:
  - `typedef enum logic {S_IDLE, S_BURST} arb_state_t`
  - `localparam NUM_CLIENTS = 2`
- Tag queue: existing `fifo` module instantiated with `FIFO_DATA_WIDTH=1`, `FIFO_BUFFER_SIZE=TAG_DEPTH`, same clock on `wr_clk` and `rd_clk`.
- State machine, counter and steering logic live in `vectorsum_arbiter`. No other sub-module.

## Test plan
- **Single client**: client 0 `len=4`, x=1..4, y=10..40 → `gnt[0]` one cycle after `req`; z 11,22,33,44 delivered only on `zvalid[0]`; `zvalid[1]` never asserts.
- **Contention round-robin**: both clients request `len=2` from reset → client 0 granted first, one idle cycle, then client 1. Results return tagged 0,0,1,1 in order.
- **Zero length**: client 1 requests `len=0` while client 0 is idle → `gnt` never asserts and the state stays `S_IDLE`.
- **Backpressure**: fill the x FIFO to full mid-burst of `len=40` → `ready[gid]=0` while `x_full`; `cnt` holds; all 40 sums arrive correct, with no duplicates or drops.
- **Return stall**: client 0 `len=8` with `zready[0]=0` until the z FIFO is full → no `z_rd_en`. Releasing `zready` drains 8 results, each tag popped in lockstep.
- **Reset mid-burst**: reset after 3 of 6 elements → all outputs 0 next cycle, tag queue empty. A following `len=2` burst from client 1 is granted and returns correct sums.
